// File: rtl/scan_coordinator_pkg.sv
// ============================================================================
// Module   : scan_coordinator_pkg
// Brief    : Shared encodings and defaults for the two-scanner coordinator.
// Revision : 1.0
// ============================================================================
`default_nettype none

package scan_coordinator_pkg;

  typedef logic [2:0] scan_state_t;

  localparam scan_state_t c_LOW_POWER = 3'b000;
  localparam scan_state_t c_STANDBY   = 3'b001;
  localparam scan_state_t c_SCANNING  = 3'b010;
  localparam scan_state_t c_IDLE      = 3'b011;
  localparam scan_state_t c_XFERRING  = 3'b100;
  localparam scan_state_t c_FLUSHING  = 3'b101;

  localparam logic [1:0] c_HWAIT  = 2'd0;
  localparam logic [1:0] c_HSTBY  = 2'd1;
  localparam logic [1:0] c_HSTART = 2'd2;
  localparam logic [1:0] c_HDONE  = 2'd3;

  localparam logic [3:0] c_DEF_STANDBY_AT = 4'd5;
  localparam logic [3:0] c_DEF_START_AT   = 4'd8;
  localparam logic [3:0] c_DEF_PROG_DONE  = 4'd10;

  // Unused codes 110/111 behave as a powered-down scanner.
  function automatic logic is_low_power(input scan_state_t s);
    return (s == c_LOW_POWER) || (s == 3'b110) || (s == 3'b111);
  endfunction

endpackage

`default_nettype wire

// File: rtl/scan_coordinator_xfer_arbiter.sv
// ============================================================================
// Module   : scan_coordinator_xfer_arbiter
// Brief    : Round-robin owner of the shared transfer channel; issues the
//            startTransfer/flush grant pulse.
// Revision : 1.0
// ============================================================================
`default_nettype none

module scan_coordinator_xfer_arbiter
  import scan_coordinator_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        flushReq_i,
  input  scan_state_t state0_i,
  input  scan_state_t state1_i,
  output logic [1:0]  startTransfer_o,
  output logic [1:0]  flush_o,
  output logic        busBusy_o,
  output logic        busOwner_o
);

  logic [1:0]  startTransfer_q, startTransfer_d;
  logic [1:0]  flush_q, flush_d;
  logic        busBusy_q, busBusy_d;
  logic        busOwner_q, busOwner_d;
  logic        lastGrant_q, lastGrant_d;
  logic        flushPending_q, flushPending_d;

  logic        w_elig0, w_elig1, w_grant, w_gnt_idx;
  logic [1:0]  w_gnt_mask;
  scan_state_t w_owner_state;

  always_comb begin
    w_elig0       = (state0_i == c_IDLE) && !busBusy_q;
    w_elig1       = (state1_i == c_IDLE) && !busBusy_q;
    w_grant       = w_elig0 || w_elig1;
    w_gnt_idx     = (w_elig0 && w_elig1) ? ~lastGrant_q : w_elig1;
    w_gnt_mask    = w_gnt_idx ? 2'b10 : 2'b01;
    w_owner_state = busOwner_q ? state1_i : state0_i;

    startTransfer_d = 2'b00;
    flush_d         = 2'b00;
    busBusy_d       = busBusy_q;
    busOwner_d      = busOwner_q;
    lastGrant_d     = lastGrant_q;

    if (busBusy_q && is_low_power(w_owner_state)) begin
      busBusy_d = 1'b0;
    end

    if (w_grant) begin
      if (flushPending_q) begin
        flush_d = w_gnt_mask;
      end else begin
        startTransfer_d = w_gnt_mask;
      end
      busBusy_d   = 1'b1;
      busOwner_d  = w_gnt_idx;
      lastGrant_d = w_gnt_idx;
    end

    // A request landing on a grant cycle is kept for the following grant.
    flushPending_d = (flushPending_q && !w_grant) || flushReq_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      startTransfer_q <= 2'b00;
      flush_q         <= 2'b00;
      busBusy_q       <= 1'b0;
      busOwner_q      <= 1'b0;
      lastGrant_q     <= 1'b1;
      flushPending_q  <= 1'b0;
    end else begin
      startTransfer_q <= startTransfer_d;
      flush_q         <= flush_d;
      busBusy_q       <= busBusy_d;
      busOwner_q      <= busOwner_d;
      lastGrant_q     <= lastGrant_d;
      flushPending_q  <= flushPending_d;
    end
  end

  assign startTransfer_o = startTransfer_q;
  assign flush_o         = flush_q;
  assign busBusy_o       = busBusy_q;
  assign busOwner_o      = busOwner_q;

endmodule

`default_nettype wire

// File: rtl/scan_coordinator.sv
// ============================================================================
// Module   : scan_coordinator
// Brief    : Ping-pongs scanning between two scanners and arbitrates the
//            shared transfer channel.
// Revision : 1.0
// ============================================================================
`default_nettype none

module scan_coordinator
  import scan_coordinator_pkg::*;
#(
  parameter logic [3:0] STANDBY_AT = c_DEF_STANDBY_AT,
  parameter logic [3:0] START_AT   = c_DEF_START_AT,
  parameter logic [3:0] PROG_DONE  = c_DEF_PROG_DONE
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        run_i,
  input  logic        flushReq_i,
  input  scan_state_t state0_i,
  input  scan_state_t state1_i,
  input  logic [3:0]  prog0_i,
  input  logic [3:0]  prog1_i,
  output logic [1:0]  goToStandby_o,
  output logic [1:0]  startScan_o,
  output logic [1:0]  startTransfer_o,
  output logic [1:0]  flush_o,
  output logic        active_o,
  output logic        busBusy_o,
  output logic        busOwner_o
);

  logic [1:0]  hstate_q, hstate_d;
  logic        active_q, active_d;
  logic [1:0]  goToStandby_q, goToStandby_d;
  logic [1:0]  startScan_q, startScan_d;

  logic [3:0]  w_prog_act;
  scan_state_t w_st_act, w_st_oth;
  logic [1:0]  w_oth_mask;

  always_comb begin
    w_prog_act = active_q ? prog1_i : prog0_i;
    w_st_act   = active_q ? state1_i : state0_i;
    w_st_oth   = active_q ? state0_i : state1_i;
    w_oth_mask = active_q ? 2'b01 : 2'b10;

    hstate_d      = hstate_q;
    active_d      = active_q;
    goToStandby_d = 2'b00;
    startScan_d   = 2'b00;

    case (hstate_q)
      c_HWAIT: begin
        // A finished scan is no longer a valid handoff source.
        if (run_i && (w_st_act == c_SCANNING) && (w_prog_act >= STANDBY_AT) &&
            (w_prog_act < PROG_DONE) && (w_st_oth == c_LOW_POWER)) begin
          goToStandby_d = w_oth_mask;
          hstate_d      = c_HSTBY;
        end
      end
      c_HSTBY: begin
        if (w_prog_act >= START_AT) begin
          startScan_d = w_oth_mask;
          hstate_d    = c_HSTART;
        end
      end
      c_HSTART: begin
        if (w_st_oth == c_SCANNING) begin
          active_d = ~active_q;
          hstate_d = c_HDONE;
        end
      end
      c_HDONE: begin
        if (w_prog_act < STANDBY_AT) begin
          hstate_d = c_HWAIT;
        end
      end
      default: hstate_d = c_HWAIT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hstate_q      <= c_HWAIT;
      active_q      <= 1'b0;
      goToStandby_q <= 2'b00;
      startScan_q   <= 2'b00;
    end else begin
      hstate_q      <= hstate_d;
      active_q      <= active_d;
      goToStandby_q <= goToStandby_d;
      startScan_q   <= startScan_d;
    end
  end

  scan_coordinator_xfer_arbiter u_xfer_arbiter (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .flushReq_i      (flushReq_i),
    .state0_i        (state0_i),
    .state1_i        (state1_i),
    .startTransfer_o (startTransfer_o),
    .flush_o         (flush_o),
    .busBusy_o       (busBusy_o),
    .busOwner_o      (busOwner_o)
  );

  assign goToStandby_o = goToStandby_q;
  assign startScan_o   = startScan_q;
  assign active_o      = active_q;

endmodule

`default_nettype wire

// File: tb/tb_scan_coordinator.sv
// ============================================================================
// Module   : tb_scan_coordinator
// Brief    : Directed self-checking bench for scan_coordinator.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_scan_coordinator;

  localparam logic [2:0] LP = 3'b000;
  localparam logic [2:0] SB = 3'b001;
  localparam logic [2:0] SC = 3'b010;
  localparam logic [2:0] ID = 3'b011;
  localparam logic [2:0] XF = 3'b100;
  localparam logic [2:0] FL = 3'b101;

  logic       clk, reset, run, flushReq;
  logic [2:0] state0, state1;
  logic [3:0] prog0, prog1;
  logic [1:0] goToStandby, startScan, startTransfer, flush;
  logic       active, busBusy, busOwner;

  int total = 0;
  int bad   = 0;

  scan_coordinator dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .run_i           (run),
    .flushReq_i      (flushReq),
    .state0_i        (state0),
    .state1_i        (state1),
    .prog0_i         (prog0),
    .prog1_i         (prog1),
    .goToStandby_o   (goToStandby),
    .startScan_o     (startScan),
    .startTransfer_o (startTransfer),
    .flush_o         (flush),
    .active_o        (active),
    .busBusy_o       (busBusy),
    .busOwner_o      (busOwner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Command vector order: {goToStandby, startScan, startTransfer, flush}
  task automatic chk_cmd(input string tag, input logic [7:0] exp);
    chk(tag, {goToStandby, startScan, startTransfer, flush}, exp);
  endtask

  // Status order: {active, busBusy, busOwner}
  task automatic chk_st(input string tag, input logic [2:0] exp);
    chk(tag, {5'd0, active, busBusy, busOwner}, {5'd0, exp});
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; flushReq = 1'b0;
    state0 = LP; state1 = LP; prog0 = 4'd0; prog1 = 4'd0;
    tick(); tick();
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    chk_cmd("reset_cmd", 8'h00);
    chk_st("reset_status", 3'b000);

    // Handoff 0 -> 1
    run = 1'b1; state0 = SC;
    for (int p = 0; p < 5; p++) begin
      prog0 = 4'(p); tick();
      chk_cmd("pre_standby_quiet", 8'h00);
    end
    prog0 = 4'd5; tick();
    chk_cmd("gts_pulse", {2'b10, 6'b0});
    prog0 = 4'd6; state1 = SB; tick();
    chk_cmd("gts_one_cycle", 8'h00);
    prog0 = 4'd7; tick();
    chk_cmd("no_start_at7", 8'h00);
    prog0 = 4'd8; tick();
    chk_cmd("start_pulse", {2'b00, 2'b10, 4'b0});
    prog0 = 4'd9; tick();
    chk_cmd("start_one_cycle", 8'h00);
    chk_st("active_still0", 3'b000);
    state1 = SC; prog1 = 4'd0; tick();
    chk_st("active_toggled", 3'b100);

    // Transfer by scanner 0
    state0 = ID; prog0 = 4'd10; tick();
    chk_cmd("xfer0_grant", {6'b0, 2'b01, 2'b00});
    chk_st("xfer0_bus", 3'b110);
    state0 = XF; tick();
    chk_cmd("xfer0_one_cycle", 8'h00);
    chk_st("xfer0_held", 3'b110);
    state0 = LP; tick();
    chk_st("xfer0_release", 3'b100);

    // Simultaneous idle after reset: scanner 0 first
    do_reset();
    state0 = ID; state1 = ID; tick();
    chk_cmd("rr_first", {4'b0, 2'b01, 2'b00});
    chk_st("rr_first_bus", 3'b010);
    state0 = XF; tick();
    chk_cmd("rr_blocked", 8'h00);
    state0 = LP; tick();
    chk_st("rr_release", 3'b000);
    tick();
    chk_cmd("rr_second", {4'b0, 2'b10, 2'b00});
    chk_st("rr_second_bus", 3'b011);

    // Flush request consumed by next grant
    state1 = XF; tick();
    state1 = LP; tick();
    chk_st("rr_second_release", 3'b001);
    flushReq = 1'b1; tick();
    flushReq = 1'b0;
    chk_cmd("flushreq_no_grant", 8'h00);
    state1 = ID; tick();
    chk_cmd("flush_grant", {6'b0, 2'b10});
    state1 = FL; tick();
    state1 = LP; tick();
    chk_st("flush_release", 3'b001);
    state1 = ID; flushReq = 1'b1; tick();
    flushReq = 1'b0;
    chk_cmd("post_flush_xfer", {4'b0, 2'b10, 2'b00});
    state1 = XF; tick();
    state1 = LP; tick();
    state0 = ID; tick();
    chk_cmd("flushreq_at_grant_applies_next", {6'b0, 2'b01});
    chk_st("flush0_bus", 3'b010);

    // goToStandby withheld until other scanner is lowPower
    do_reset();
    run = 1'b1; state0 = SC; state1 = SB; prog0 = 4'd5; tick();
    chk_cmd("gts_withheld", 8'h00);
    state1 = LP; tick();
    chk_cmd("gts_after_lowpower", {2'b10, 6'b0});

    // run gating, threshold jump, then reset mid-handoff with bus owned
    do_reset();
    state0 = SC; prog0 = 4'd5; tick();
    chk_cmd("run_low_no_gts", 8'h00);
    run = 1'b1; prog0 = 4'd6; tick();
    chk_cmd("run_high_gts", {2'b10, 6'b0});
    prog0 = 4'd9; tick();
    chk_cmd("jump_start", {2'b00, 2'b10, 4'b0});
    state1 = ID; tick();
    chk_cmd("grant1_in_hstart", {4'b0, 2'b10, 2'b00});
    state1 = XF; tick();
    chk_st("busy_in_hstart", 3'b011);
    state1 = SC; reset = 1'b1; tick();
    chk_cmd("reset_mid_cmd", 8'h00);
    chk_st("reset_mid_status", 3'b000);
    reset = 1'b0; run = 1'b0; state0 = LP; state1 = LP; tick();
    chk_cmd("after_reset_quiet", 8'h00);
    chk_st("after_reset_status", 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
